// File: rtl/serce_pkg.sv
// Shared heart-rate package: generator FSM states and window constants.
package serce_pkg;

    typedef enum logic [1:0] {
        BEZCZYNNY  = 2'd0,
        PRACA      = 2'd1,
        WYGASZANIE = 2'd2
    } stan_gen_t;

    localparam int OKNO_DOMYSLNE = 117;
    localparam int NORMA_TETNA   = 100;

    // Highest rate that still leaves a low cycle between consecutive pulses.
    function automatic int polowa_okna(input int okno);
        return okno / 2;
    endfunction

endpackage

// File: rtl/rozklad_impulsow.sv
// Even pulse spreading: accumulate N per tick, emit a pulse and subtract
// OKNO on overflow. Optional macro GENERATOR_TETNA_JITTER_EN adds an LFSR
// that pushes a due pulse one tick later when that cannot merge pulses.
module rozklad_impulsow #(
    parameter int OKNO = 117,
    parameter int SZER = 8
) (
    input  logic            clk1,
    input  logic            reset,
    input  logic            krok,
    input  logic            zeruj,
    input  logic            ostatni,
    input  logic [SZER-1:0] n,
    output logic            impuls
);

    localparam int AW = $clog2(OKNO) + 1;
    localparam int SW = ((AW > SZER) ? AW : SZER) + 1;

    logic [AW-1:0] acc;
    logic [SW-1:0] suma;
    logic [SW-1:0] reszta;
    logic          wymagany;

    // Compare/subtract step for the current tick.
    always_comb begin
        suma     = SW'(acc) + SW'(n);
        wymagany = (suma >= SW'(OKNO));
        reszta   = wymagany ? (suma - SW'(OKNO)) : suma;
    end

    // Accumulator: cleared at window start, stepped on every active tick.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset)      acc <= '0;
        else if (zeruj) acc <= '0;
        else if (krok)  acc <= AW'(reszta);
    end

`ifdef GENERATOR_TETNA_JITTER_EN
    logic [15:0]   lfsr;
    logic          oczekuje;
    logic          nast_wymagany;
    logic          odloz;
    logic [SW-1:0] suma_nast;

    // A pulse may slip one tick only into a free slot, never past the window end.
    always_comb begin
        suma_nast     = reszta + SW'(n);
        nast_wymagany = (suma_nast >= SW'(OKNO));
        odloz         = wymagany && lfsr[0] && !nast_wymagany && !ostatni;
        impuls        = (wymagany && !odloz) || oczekuje;
    end

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, one step per active tick.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset)     lfsr <= 16'hACE1;
        else if (krok) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    // Remembers a pulse pushed into the next tick.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset)      oczekuje <= 1'b0;
        else if (zeruj) oczekuje <= 1'b0;
        else if (krok)  oczekuje <= odloz;
    end
`else
    logic unused_ostatni;
    assign unused_ostatni = ostatni;
    assign impuls         = wymagany;
`endif

endmodule

// File: rtl/generator_tetna.sv
// Synthetic heartbeat source: exactly N single-cycle pulses per OKNO-tick
// window, evenly spread. Optional macro: GENERATOR_TETNA_JITTER_EN.
// Pipeline: tick evaluated -> stage register -> output registers.
import serce_pkg::*;

module generator_tetna #(
    parameter int OKNO = OKNO_DOMYSLNE,
    parameter int SZER = 8
) (
    input  logic            clk1,
    input  logic            reset,
    input  logic            start,
    input  logic            stop,
    input  logic [SZER-1:0] tetno_zadane,
    output logic            puls,
    output logic            koniec_okna,
    output logic [SZER-1:0] licznik_impulsow,
    output logic [SZER-1:0] ostatnia_liczba,
    output logic            nasycenie,
    output logic            zajety
);

    localparam int              TW     = $clog2(OKNO);
    localparam int              STAGES = 2;
    localparam logic [SZER-1:0] LIMIT  = SZER'(polowa_okna(OKNO));

    stan_gen_t       stan, stan_nast;
    logic [TW-1:0]   tick;
    logic [SZER-1:0] n_reg;
    logic [SZER-1:0] licznik_nowy;
    logic            krok, ostatni, start_okna, z_bezczynnosci, impuls;
    logic            etap_imp, etap_ost, etap_pierw;
    logic [STAGES:0] vld_pipe;

    // Next state plus the window-start decision derived from it.
    always_comb begin
        stan_nast = stan;
        krok      = (stan != BEZCZYNNY);
        ostatni   = krok && (tick == TW'(OKNO - 1));
        case (stan)
            BEZCZYNNY:  if (start && !stop) stan_nast = PRACA;
            PRACA:      if (stop) stan_nast = WYGASZANIE;
            WYGASZANIE: begin
                if (start && !stop) stan_nast = PRACA;
                else if (ostatni)   stan_nast = BEZCZYNNY;
            end
            default:    stan_nast = BEZCZYNNY;
        endcase
        z_bezczynnosci = (stan == BEZCZYNNY) && (stan_nast == PRACA);
        start_okna     = z_bezczynnosci || (ostatni && (stan_nast != BEZCZYNNY));
    end

    // State register.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) stan <= BEZCZYNNY;
        else       stan <= stan_nast;
    end

    // Window counter and per-window rate latch with clamp.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            tick      <= '0;
            n_reg     <= '0;
            nasycenie <= 1'b0;
        end else if (start_okna) begin
            tick      <= '0;
            n_reg     <= (tetno_zadane > LIMIT) ? LIMIT : tetno_zadane;
            nasycenie <= (tetno_zadane > LIMIT);
        end else if (ostatni) begin
            tick <= '0;
        end else if (krok) begin
            tick <= tick + 1'b1;
        end
    end

    rozklad_impulsow #(
        .OKNO (OKNO),
        .SZER (SZER)
    ) u_rozklad (
        .clk1    (clk1),
        .reset   (reset),
        .krok    (krok),
        .zeruj   (start_okna),
        .ostatni (ostatni),
        .n       (n_reg),
        .impuls  (impuls)
    );

    // Stage register holding the tick's result, plus the activity shift register.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            vld_pipe   <= '0;
            etap_imp   <= 1'b0;
            etap_ost   <= 1'b0;
            etap_pierw <= 1'b0;
        end else begin
            vld_pipe   <= {vld_pipe[STAGES-1:0], stan_nast != BEZCZYNNY};
            etap_imp   <= krok && impuls;
            etap_ost   <= ostatni;
            etap_pierw <= krok && (tick == '0);
        end
    end

    // Running count restarts from the first tick's result of each window.
    always_comb begin
        licznik_nowy = (etap_pierw ? '0 : licznik_impulsow) + SZER'(etap_imp);
    end

    // Output registers, one cycle behind the stage register.
    always_ff @(posedge clk1 or posedge reset) begin
        if (reset) begin
            puls             <= 1'b0;
            koniec_okna      <= 1'b0;
            licznik_impulsow <= '0;
            ostatnia_liczba  <= '0;
        end else begin
            puls        <= vld_pipe[1] && etap_imp;
            koniec_okna <= vld_pipe[1] && etap_ost;
            if (vld_pipe[1]) begin
                licznik_impulsow <= licznik_nowy;
                if (etap_ost) ostatnia_liczba <= licznik_nowy;
            end else if (z_bezczynnosci) begin
                licznik_impulsow <= '0;
            end
        end
    end

    // Busy until the last window's outputs have drained.
    assign zajety = |vld_pipe;

endmodule

// File: doc/generator_tetna.md
# generator_tetna

Synthetic heartbeat source for the heart-rate monitor. Produces a train of single-cycle pulses, spread evenly across a fixed measurement window, so that exactly the requested number of beats lands in each window. Its `puls` output drives the monitor's beat-clock input. Its window timing runs on the same time-base clock the monitor uses for its window counter. It is the stimulus/transmit end of the beat-counting interface.

## Interface
Parameters:
- `OKNO`, 117: window length in clock ticks (must match the monitor's window terminal count).
- `SZER`, 8: width of rate and count buses.

Ports:
- `clk1`, in, 1: time-base clock. The block has one clock; all logic is on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: level-sampled; begins or continues generation.
- `stop`, in, 1: level-sampled; ends generation at the next window boundary.
- `tetno_zadane`, in, SZER: requested beats per window.
- `puls`, out, 1: registered beat pulse, one cycle high.
- `koniec_okna`, out, 1: one-cycle strobe on the last tick of each window.
- `licznik_impulsow`, out, SZER: pulses emitted so far in the current window.
- `ostatnia_liczba`, out, SZER: total pulses of the last completed window.
- `nasycenie`, out, 1: the latched rate was clamped.
- `zajety`, out, 1: high when state is not BEZCZYNNY.

## Operation
- States:
  - BEZCZYNNY: `start`=1 and `stop`=0 → PRACA.
  - PRACA: `stop`=1 → WYGASZANIE.
  - WYGASZANIE: `start`=1 and `stop`=0 → PRACA. Otherwise → BEZCZYNNY at the last tick of the window.
  - In BEZCZYNNY, `stop` dominates `start`.
- Window start (entering PRACA from BEZCZYNNY, or tick 0 of every later window):
  - N is latched as min(`tetno_zadane`, OKNO/2), i.e. 58 by default.
  - `nasycenie` is set when clamping occurred, cleared otherwise.
  - Accumulator and `licznik_impulsow` are cleared.
  - `tetno_zadane` is ignored between window starts.
- Per tick t = 0..OKNO-1:
  - s = acc + N.
  - If s ≥ OKNO: `puls` goes high in the next cycle, acc ← s − OKNO, and `licznik_impulsow` increments.
  - Else acc ← s.
  - This yields exactly N pulses per window. The last pulse is issued on tick OKNO-1 when N > 0.
  - The clamp to OKNO/2 guarantees at least one low cycle between pulses, so the monitor counts each edge separately.
- Accumulator width: clog2(OKNO)+1 bits. It cannot overflow, since acc < OKNO and N ≤ OKNO/2.
- Window counter runs 0..OKNO-1 and wraps to 0.
- At tick OKNO-1:
  - `koniec_okna` pulses.
  - `ostatnia_liczba` ← final count, including a pulse issued on that tick.
- N = 0: no pulses; `koniec_okna` still strobes every OKNO cycles.
- Reset values: state BEZCZYNNY; every output 0; accumulator 0; window counter 0.
- Reset asserted mid-window: the window is abandoned and all outputs drop to 0 immediately (asynchronous).

## Timing
- `start` sampled high in BEZCZYNNY at edge k: tick 0 evaluates at edge k+1. The earliest `puls` is at edge k+2.
- `puls` and `koniec_okna` are registered, with one cycle of latency from tick evaluation.
- Consecutive windows are back-to-back, with no idle cycle between them.
- `zajety` falls in the cycle after the final `koniec_okna` of WYGASZANIE.

## Configuration
- `GENERATOR_TETNA_JITTER_EN` defined:
  - A 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 0xACE1 on reset) steps every tick.
  - When the LFSR's bit 0 is 1, a due pulse is delayed by one tick.
  - The delay is applied only if no pulse is due on the next tick and the current tick is not OKNO-1.
  - Per-window count stays exactly N.
- Undefined:
  - No LFSR is present and pulse placement is purely deterministic.

## Structure
- Shared package `serce_pkg`:
  - state enum `stan_gen_t` (BEZCZYNNY, PRACA, WYGASZANIE);
  - `OKNO_DOMYSLNE` = 117;
  - `NORMA_TETNA` = 100.
- Sub-module `rozklad_impulsow`: the accumulator/compare/subtract step plus the optional jitter delay. The top level holds the FSM, window counter and output registers.

## Test plan
- Reset, then `tetno_zadane`=40 and start → 40 pulses per window, first `puls` at edge k+4, never two adjacent high cycles, `ostatnia_liczba`=40.
- `tetno_zadane`=100 → 58 pulses per window, `nasycenie`=1; then set 50 → `nasycenie`=0 from the next window.
- `tetno_zadane`=0 → no `puls`, `koniec_okna` every 117 cycles, `ostatnia_liczba`=0.
- Change 30→70 at tick 60 → current window gives 30 pulses, next window gives 58 (clamped from 70).
- `stop` at tick 20 → window completes with N pulses, `zajety` drops after `koniec_okna`; `start` re-asserted at tick 50 of the draining window → generation continues.
- Async `reset` at tick 80 → all outputs 0 in the same cycle; restart yields a full clean window.
